// File: rtl/voq_rr_reader_pkg.sv
// Shared types and width helpers for the VOQ round-robin reader.
package voq_rr_reader_pkg;

    // Output buffer occupancy; the encoding equals the entry count.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_TWO  = 2'd2
    } buf_state_e;

    // clog2 that never returns 0, so single-channel/tiny builds keep 1-bit fields.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/voq_rr_reader_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr (wrapping) wins.
module voq_rr_reader_rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int k;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/voq_rr_reader.sv
// Drains a multi-channel FIFO round-robin into a 2-entry in-order output buffer,
// counting pops per channel.
module voq_rr_reader
    import voq_rr_reader_pkg::*;
#(
    parameter  int PORT_NUB   = 4,
    parameter  int DEPTH      = 100,
    parameter  int CNT_W      = 16,
    localparam int WIDTH_PORT = clog2_min1(DEPTH),
    localparam int WIDTH_SEL  = clog2_min1(PORT_NUB)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PORT_NUB-1:0]       empty,
    input  logic [PORT_NUB-1:0]       port_en,
    output logic                      rd_en,
    output logic [WIDTH_SEL-1:0]      rd_sel,
    input  logic [WIDTH_PORT-1:0]     rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH_PORT-1:0]     out_data,
    output logic [WIDTH_SEL-1:0]      out_port,
    output logic [PORT_NUB*CNT_W-1:0] pop_cnt
);

    logic [PORT_NUB-1:0]                 cand;
    logic [PORT_NUB-1:0]                 grant;
    logic [WIDTH_SEL-1:0]                win_idx;
    logic                                win_any;
    logic [WIDTH_SEL-1:0]                rr_ptr;
    buf_state_e                          state, state_nxt;
    logic [1:0][WIDTH_PORT-1:0]          buf_data;
    logic [1:0][WIDTH_SEL-1:0]           buf_port;
    logic [PORT_NUB-1:0][CNT_W-1:0]      cnt;
    logic                                deq, full, push;

    assign cand = ~empty & port_en;

    voq_rr_reader_rr_arbiter #(.N(PORT_NUB), .SEL_W(WIDTH_SEL)) u_arb (
        .req   (cand),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign out_valid = (state != ST_IDLE);
    assign deq       = out_valid & out_ready;
    // A dequeue in the same cycle frees a slot, so TWO only blocks without one.
    assign full      = (state == ST_TWO) && !deq;
    assign rd_en     = !rst && win_any && !full;
    assign rd_sel    = rd_en ? win_idx : '0;
    assign push      = rd_en;
    assign out_data  = buf_data[0];
    assign out_port  = buf_port[0];
    assign pop_cnt   = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (deq && !push)
                    state_nxt = ST_IDLE;
                else if (push && !deq)
                    state_nxt = ST_TWO;
            end
            ST_TWO:  if (deq && !push) state_nxt = ST_ONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Entry 0 is always the head; entry 1 shifts forward on dequeue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data <= '0;
            buf_port <= '0;
        end else begin
            case (state)
                ST_IDLE: if (push) begin
                    buf_data[0] <= rd_data;
                    buf_port[0] <= rd_sel;
                end
                ST_ONE: begin
                    if (push && deq) begin
                        buf_data[0] <= rd_data;
                        buf_port[0] <= rd_sel;
                    end else if (push) begin
                        buf_data[1] <= rd_data;
                        buf_port[1] <= rd_sel;
                    end
                end
                ST_TWO: if (deq) begin
                    buf_data[0] <= buf_data[1];
                    buf_port[0] <= buf_port[1];
                    if (push) begin
                        buf_data[1] <= rd_data;
                        buf_port[1] <= rd_sel;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (rd_en)
            rr_ptr <= (win_idx == WIDTH_SEL'(PORT_NUB - 1)) ? '0 : win_idx + 1'b1;
    end

    for (genvar g = 0; g < PORT_NUB; g++) begin : g_cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt[g] <= '0;
            else if (rd_en && grant[g])
                cnt[g] <= cnt[g] + 1'b1;
        end
    end

endmodule

// File: doc/voq_rr_reader.md
VOQ_RR_READER -- requirements
Module: voq_rr_reader

Interface
REQ-001 Parameter PORT_NUB, default 4, number of channels in the multi-channel free/queue FIFO being drained.
REQ-002 Parameter DEPTH, default 100, per-channel depth; WIDTH_PORT = clog2(DEPTH), WIDTH_SEL = clog2(PORT_NUB).
REQ-003 Parameter CNT_W, default 16, width of each per-port pop counter.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high; clears all state.
REQ-006 empty  in  PORT_NUB  per-channel empty flags from FIFO; registered at the FIFO, valid the cycle after a pop.
REQ-007 port_en  in  PORT_NUB  per-channel service enable; disabled channels are never selected.
REQ-008 rd_en  out  1  pop strobe to FIFO.
REQ-009 rd_sel  out  WIDTH_SEL  channel being popped; valid whenever rd_en=1.
REQ-010 rd_data  in  WIDTH_PORT  FIFO head of channel rd_sel, combinational in the same cycle as rd_sel.
REQ-011 out_valid  out  1  output entry available.
REQ-012 out_ready  in  1  downstream accepts when out_valid & out_ready.
REQ-013 out_data  out  WIDTH_PORT  popped value.
REQ-014 out_port  out  WIDTH_SEL  channel the value came from.
REQ-015 pop_cnt  out  PORT_NUB*CNT_W  per-channel pop counters, channel i at bits [i*CNT_W +: CNT_W].

Function
REQ-016 Candidate set = ~empty & port_en; pop issued only when candidate set non-zero and output buffer not full.
REQ-017 Round-robin: search starts at rr_ptr, wraps modulo PORT_NUB; first candidate wins.
REQ-018 After a pop of channel p, rr_ptr <= (p+1) mod PORT_NUB; rr_ptr unchanged in cycles without a pop.
REQ-019 rd_en, rd_sel combinational from registered state and inputs; rd_sel = 0 when rd_en = 0.
REQ-020 On pop, {rd_data, rd_sel} written into a 2-entry output buffer in the same cycle; out_valid rises next cycle (latency 1).
REQ-021 Output buffer in-order; count 0..2; out_data/out_port show head entry, hold stable while out_valid & ~out_ready.
REQ-022 Buffer "full" = count==2 and no dequeue this cycle; simultaneous push and pop at count 2 permitted (count stays 2).
REQ-023 Simultaneous push and pop at count 1: count stays 1, new entry becomes head next cycle.
REQ-024 Sustained throughput 1 pop/cycle when out_ready held high and candidates exist.
REQ-025 Back-to-back pops of same channel permitted; empty is trusted on the cycle it is sampled.
REQ-026 port_en change takes effect in the same cycle; entries already buffered are still delivered.
REQ-027 pop_cnt[i] increments by 1 on each pop of channel i, wraps from 2^CNT_W-1 to 0.
REQ-028 State machine: IDLE (count 0), ONE (count 1), TWO (count 2); transitions per push/pop pair: IDLE->ONE push; ONE->IDLE pop; ONE->TWO push only; TWO->ONE pop only; push&pop hold state.

Reset
REQ-029 On rst: rr_ptr=0, count=0 (IDLE), out_valid=0, out_data=0, out_port=0, all pop_cnt=0; rd_en=0 during reset.
REQ-030 Reset mid-operation discards buffered entries; no pop issued while rst=1.

Structure
REQ-031 WIDTH_PORT/WIDTH_SEL derivations and state encoding constants live in generate_parameter.vh.
REQ-032 One sub-module natural: rr_arbiter (PORT_NUB request vector + pointer -> one-hot grant + index).

Verification
REQ-033 PORT_NUB=4, empty=4'b0000, port_en=4'b1111, out_ready=1 -> rd_sel sequence 0,1,2,3,0; out_port follows one cycle later.
REQ-034 empty=4'b1010, rr_ptr=1 -> first pop rd_sel=2, next rd_sel=0; channels 1,3 never popped.
REQ-035 out_ready=0, all channels non-empty -> exactly 2 pops then rd_en=0; out_data holds first value; release ready -> order preserved.
REQ-036 port_en=4'b0100, channel 2 has 3 entries (values 5,9,12) -> 3 consecutive pops, out_data 5,9,12, pop_cnt[2]=3, rd_en=0 after empty[2]=1.
REQ-037 CNT_W=4, 17 pops of channel 0 -> pop_cnt[0]=1.
REQ-038 Assert rst with count=2 -> next cycle out_valid=0, rr_ptr=0, all pop_cnt=0.
